// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues single-cycle-latency
// reads to instruction memory and buffers {pc, instr} pairs for decode.
module fetch_queue #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      ADDR_W   = 11,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       MEM_REQ,
  output logic [ADDR_W-1:0]          MEM_ADR,
  input  logic [WIDTH-1:0]           MEM_RDATA,
  input  logic                       REDIRECT,
  input  logic [WIDTH-1:0]           REDIRECT_PC,
  input  logic                       READY_IN,
  output logic                       VALID_OUT,
  output logic [WIDTH-1:0]           PC_OUT,
  output logic [WIDTH-1:0]           INSTR_OUT,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned      PTR_W = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] NOP   = WIDTH'(32'h0000_0013);

  logic [WIDTH-1:0] fetch_pc_q,  fetch_pc_d;
  logic [WIDTH-1:0] issued_pc_q, issued_pc_d;
  logic             inflight_q,  inflight_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;

  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [WIDTH-1:0] instr_mem_q [DEPTH];

  logic             valid;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   credit;

  // Credit counts the in-flight read as occupied so a response always has a slot.
  always_comb begin
    valid  = (count_q != '0);
    pop    = valid & READY_IN & ~REDIRECT;
    push   = inflight_q & ~REDIRECT;
    credit = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    issue  = rst & ~REDIRECT & (credit < (CNT_W+1)'(DEPTH));
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = fetch_pc_q;
    inflight_d  = issue;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    if (REDIRECT) begin
      fetch_pc_d = REDIRECT_PC & ~WIDTH'(3);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + WIDTH'(4);
      if (push)  wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q gates every
  // read, so stale contents can never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem_q[wr_ptr_q]    <= issued_pc_q;
      instr_mem_q[wr_ptr_q] <= MEM_RDATA;
    end
  end

  assign MEM_REQ   = issue;
  assign MEM_ADR   = fetch_pc_q[ADDR_W+1:2];
  assign VALID_OUT = valid;
  assign PC_OUT    = valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign INSTR_OUT = valid ? instr_mem_q[rd_ptr_q] : NOP;
  assign COUNT     = count_q;

endmodule
